// File: rtl/memory_stage.sv
// memory_stage: Y86-64 sequential CPU memory stage.
// Latches execute results on start. Runs a req/ack data-memory access for memory
// icodes, with an address-limit check and a bounded ack wait. Reports done/stat.
// Optional feature: define MEM_ALIGN_CHECK_EN to treat addr[2:0] != 0 as an address error.
module memory_stage #(
  parameter logic [63:0] ADDR_LIMIT = 64'h1000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] valM,
  output logic [2:0]  stat,
  output logic        done,
  output logic        busy
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_HALTED} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [63:0] valm_q, valm_d;
  logic [2:0]  stat_q, stat_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        sel_mem;
  logic        sel_we;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        sel_bad;

  // Decode the incoming icode into the access it would perform
  always_comb begin
    sel_mem   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = valE;
    sel_wdata = valA;
    case (icode)
      I_RMMOVQ, I_PUSHQ: begin sel_mem = 1'b1; sel_we = 1'b1; end
      I_CALL:            begin sel_mem = 1'b1; sel_we = 1'b1; sel_wdata = valP; end
      I_MRMOVQ:          sel_mem = 1'b1;
      I_POPQ, I_RET:     begin sel_mem = 1'b1; sel_addr = valA; end
      default:           sel_mem = 1'b0;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    sel_bad = (sel_addr >= ADDR_LIMIT) || (sel_addr[2:0] != 3'b000);
`else
    sel_bad = (sel_addr >= ADDR_LIMIT);
`endif
  end

  // Next-state, datapath register updates and status
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    valm_d  = valm_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          // Only the resolved address/data/direction are kept; raw valE/valA/valP
          // are not needed after selection.
          if (sel_mem) begin
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            we_d    = sel_we;
          end
          if (icode == I_HALT) begin
            stat_d  = STAT_HLT;
            state_d = S_DONE;
          end else if (!sel_mem) begin
            stat_d  = STAT_AOK;
            state_d = S_DONE;
          end else if (sel_bad) begin
            stat_d  = STAT_ADR;
            state_d = S_DONE;
          end else begin
            stat_d  = STAT_AOK;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Ack is checked before the wait limit so a last-cycle ack still completes
        if (mem_ack) begin
          if (!we_q) valm_d = mem_rdata;
          stat_d  = STAT_AOK;
          state_d = S_DONE;
        end else if (cnt_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:   state_d = (stat_q == STAT_AOK) ? S_IDLE : S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      valm_q  <= '0;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign valM      = valm_q;
  assign stat      = stat_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_REQ) || (state_q == S_DONE);

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (TIMEOUT overridden to 4).
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        done, busy;

  int checks   = 0;
  int failures = 0;
  logic req_seen = 1'b0;

  memory_stage #(.ADDR_LIMIT(64'h1000), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valM(valM), .stat(stat), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (mem_req === 1'b1) req_seen = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst_req",   {63'd0, mem_req}, 64'd0);
    check("rst_we",    {63'd0, mem_we}, 64'd0);
    check("rst_addr",  mem_addr, 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_valM",  valM, 64'd0);
    check("rst_stat",  {61'd0, stat}, 64'd1);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    reset = 1'b1;
    step();

    // MRMOVQ 0x100, ack in third REQ cycle, done 4 cycles after start
    issue(4'h5, 64'h100, 64'h55, 64'h0);
    check("mr_req1",  {63'd0, mem_req}, 64'd1);
    check("mr_we",    {63'd0, mem_we}, 64'd0);
    check("mr_addr",  mem_addr, 64'h100);
    check("mr_busy",  {63'd0, busy}, 64'd1);
    step();
    check("mr_req2",  {63'd0, mem_req}, 64'd1);
    check("mr_done2", {63'd0, done}, 64'd0);
    step();
    check("mr_req3",  {63'd0, mem_req}, 64'd1);
    mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    check("mr_done",  {63'd0, done}, 64'd1);
    check("mr_valM",  valM, 64'hDEADBEEF);
    check("mr_stat",  {61'd0, stat}, 64'd1);
    check("mr_reqlo", {63'd0, mem_req}, 64'd0);
    step();
    check("mr_pulse", {63'd0, done}, 64'd0);
    check("mr_idle",  {63'd0, busy}, 64'd0);

    // CALL with immediate ack
    issue(4'h8, 64'h1F8, 64'h99, 64'h42);
    mem_ack = 1'b1; mem_rdata = 64'h7777;
    check("call_req",   {63'd0, mem_req}, 64'd1);
    check("call_we",    {63'd0, mem_we}, 64'd1);
    check("call_addr",  mem_addr, 64'h1F8);
    check("call_wdata", mem_wdata, 64'h42);
    step();
    mem_ack = 1'b0;
    check("call_done",  {63'd0, done}, 64'd1);
    check("call_valM",  valM, 64'hDEADBEEF);
    check("call_stat",  {61'd0, stat}, 64'd1);
    step();

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 64'h5555;
    step();
    step();
    mem_ack = 1'b0;
    check("idleack_valM", valM, 64'hDEADBEEF);
    check("idleack_req",  {63'd0, mem_req}, 64'd0);
    check("idleack_done", {63'd0, done}, 64'd0);

    // Last legal address; start while busy is ignored
    issue(4'h5, 64'hFF8, 64'h0, 64'h0);
    check("lim_req",  {63'd0, mem_req}, 64'd1);
    check("lim_addr", mem_addr, 64'hFF8);
    icode = 4'hA; valE = 64'h40; valA = 64'h77; start = 1'b1;
    step();
    start = 1'b0;
    check("busy_addr", mem_addr, 64'hFF8);
    check("busy_we",   {63'd0, mem_we}, 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'hABCD;
    step();
    mem_ack = 1'b0;
    check("lim_done", {63'd0, done}, 64'd1);
    check("lim_valM", valM, 64'hABCD);
    step();
    check("busy_noop", {63'd0, busy}, 64'd0);
    step();
    check("busy_nodone", {63'd0, done}, 64'd0);

    // Ack in the fourth (last) REQ cycle wins over the timeout
    issue(4'h5, 64'h200, 64'h0, 64'h0);
    step();
    step();
    step();
    check("win_req4", {63'd0, mem_req}, 64'd1);
    mem_ack = 1'b1; mem_rdata = 64'h1234;
    step();
    mem_ack = 1'b0;
    check("win_done", {63'd0, done}, 64'd1);
    check("win_stat", {61'd0, stat}, 64'd1);
    check("win_valM", valM, 64'h1234);
    step();

    // OPQ: no memory access, done next cycle
    req_seen = 1'b0;
    issue(4'h6, 64'h300, 64'h0, 64'h0);
    check("opq_done", {63'd0, done}, 64'd1);
    check("opq_stat", {61'd0, stat}, 64'd1);
    check("opq_busy", {63'd0, busy}, 64'd1);
    step();
    check("opq_done2", {63'd0, done}, 64'd0);
    check("opq_noreq", {63'd0, req_seen}, 64'd0);
    check("opq_valM",  valM, 64'h1234);

    // Timeout after 4 REQ cycles, then halted
    issue(4'h5, 64'h300, 64'h0, 64'h0);
    check("to_req1", {63'd0, mem_req}, 64'd1);
    step();
    check("to_req2", {63'd0, mem_req}, 64'd1);
    step();
    check("to_req3", {63'd0, mem_req}, 64'd1);
    step();
    check("to_req4", {63'd0, mem_req}, 64'd1);
    step();
    check("to_reqlo", {63'd0, mem_req}, 64'd0);
    check("to_done",  {63'd0, done}, 64'd1);
    check("to_stat",  {61'd0, stat}, 64'd3);
    check("to_valM",  valM, 64'h1234);
    step();
    check("to_halt_busy", {63'd0, busy}, 64'd0);
    check("to_halt_done", {63'd0, done}, 64'd0);
    issue(4'h6, 64'h0, 64'h0, 64'h0);
    check("halt_ign_done", {63'd0, done}, 64'd0);
    check("halt_ign_busy", {63'd0, busy}, 64'd0);
    check("halt_ign_stat", {61'd0, stat}, 64'd3);

    // POPQ at ADDR_LIMIT: illegal, no request
    pulse_reset();
    req_seen = 1'b0;
    issue(4'hB, 64'h0, 64'h1000, 64'h0);
    check("pop_done", {63'd0, done}, 64'd1);
    check("pop_stat", {61'd0, stat}, 64'd3);
    check("pop_req",  {63'd0, mem_req}, 64'd0);
    step();
    check("pop_noreq", {63'd0, req_seen}, 64'd0);
    issue(4'h6, 64'h0, 64'h0, 64'h0);
    check("pop_ign_busy", {63'd0, busy}, 64'd0);
    check("pop_ign_done", {63'd0, done}, 64'd0);

    // Reset asserted mid-REQ drops mem_req without a clock edge
    pulse_reset();
    issue(4'h5, 64'h100, 64'h0, 64'h0);
    check("rr_req", {63'd0, mem_req}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rr_reqlo", {63'd0, mem_req}, 64'd0);
    check("rr_busy",  {63'd0, busy}, 64'd0);
    step();
    check("rr_done", {63'd0, done}, 64'd0);
    #3 reset = 1'b1;
    step();
    check("rr_stat", {61'd0, stat}, 64'd1);
    check("rr_valM", valM, 64'd0);
    check("rr_done2", {63'd0, done}, 64'd0);

    // HALT
    issue(4'h0, 64'h0, 64'h0, 64'h0);
    check("hlt_done", {63'd0, done}, 64'd1);
    check("hlt_stat", {61'd0, stat}, 64'd2);
    step();
    check("hlt_busy", {63'd0, busy}, 64'd0);
    check("hlt_stat2", {61'd0, stat}, 64'd2);

    // RMMOVQ to a misaligned address
    pulse_reset();
    req_seen = 1'b0;
    issue(4'h4, 64'h103, 64'h66, 64'h0);
`ifdef MEM_ALIGN_CHECK_EN
    check("al_done", {63'd0, done}, 64'd1);
    check("al_stat", {61'd0, stat}, 64'd3);
    step();
    check("al_noreq", {63'd0, req_seen}, 64'd0);
`else
    check("al_req",   {63'd0, mem_req}, 64'd1);
    check("al_addr",  mem_addr, 64'h103);
    check("al_wdata", mem_wdata, 64'h66);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("al_done", {63'd0, done}, 64'd1);
    check("al_stat", {61'd0, stat}, 64'd1);
    check("al_valM", valM, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
